// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing constants for the 640x480@60 scan-out (porches, sync
//   widths, totals), the default colour-pipeline latency, and the bundle
//   of per-pixel timing bits that travels alongside the colour pipeline.
//   No ports; imported by vga_scanout and sync_delay.
package vga_timing_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FRONT  = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BACK   = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FRONT  = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BACK   = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  localparam int VGA_PIPE_LAT = 4;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 10;

  // Timing bits for one pixel slot; syncs are active-low.
  typedef struct packed {
    logic active;
    logic hsync;
    logic vsync;
  } sync_bits_t;

  // Value carried by the delay line outside any visible/sync interval.
  localparam sync_bits_t SYNC_IDLE = '{active: 1'b0, hsync: 1'b1, vsync: 1'b1};

endpackage

// File: rtl/sync_delay.sv
// sync_delay
//   Fixed-depth shift register for the {active, hsync, vsync} bundle so the
//   timing bits line up with colour returned by an external pipeline.
//   Ports:
//     clk   pixel clock
//     rst   asynchronous reset, active-low; every stage returns to SYNC_IDLE
//     din   timing bits for the pixel currently being requested
//     dout  the same bits DEPTH clocks later
module sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = VGA_PIPE_LAT
) (
  input  logic       clk,
  input  logic       rst,
  input  sync_bits_t din,
  output sync_bits_t dout
);

  sync_bits_t stages [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stages[i] <= SYNC_IDLE;
      end
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout
//   VGA timing generator and DAC output stage. Requests pixel coordinates
//   from an external colour generator, waits PIPE_LAT clocks for the colour
//   to come back, and registers colour, syncs and blank together so the
//   monitor sees them aligned (sync-to-request latency PIPE_LAT+1).
//   PIPE_LAT must lie in 1..15.
//   Ports:
//     clk              pixel clock, all state on its rising edge
//     rst              asynchronous reset, active-low
//     x_out, y_out     requested column/row, 0 outside the active area
//     red/green/blue   colour for the request made PIPE_LAT clocks earlier
//     vga_r/g/b        registered DAC colour, 0 while blanked
//     vga_hs, vga_vs   registered syncs, active-low
//     vga_blank_n      registered, low outside the active area
//     frame_start      one-clock pulse with the request for pixel (0,0)
module vga_scanout
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FRONT  = VGA_H_FRONT,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BACK   = VGA_H_BACK,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FRONT  = VGA_V_FRONT,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BACK   = VGA_V_BACK,
  parameter int PIPE_LAT = VGA_PIPE_LAT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  input  logic [COLOR_W-1:0] red,
  input  logic [COLOR_W-1:0] green,
  input  logic [COLOR_W-1:0] blue,
  output logic [COLOR_W-1:0] vga_r,
  output logic [COLOR_W-1:0] vga_g,
  output logic [COLOR_W-1:0] vga_b,
  output logic               vga_hs,
  output logic               vga_vs,
  output logic               vga_blank_n,
  output logic               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam int H_SYNC_START = H_ACTIVE + H_FRONT;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FRONT;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_wrap;
  logic          v_wrap;
  sync_bits_t    raw_bits;
  sync_bits_t    dly_bits;

  assign h_wrap = (32'(h_cnt) == H_TOTAL - 1);
  assign v_wrap = (32'(v_cnt) == V_TOTAL - 1);

  // Raster position; the row only advances when the column wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= v_wrap ? '0 : v_cnt + VW'(1);
    end else begin
      h_cnt <= h_cnt + HW'(1);
    end
  end

  // Timing bits for the pixel being requested this clock. Comparisons are
  // done at 32 bits so a sync interval ending exactly at the total cannot
  // wrap in the counter width.
  always_comb begin
    raw_bits        = SYNC_IDLE;
    raw_bits.active = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
    raw_bits.hsync  = !((32'(h_cnt) >= H_SYNC_START) && (32'(h_cnt) < H_SYNC_END));
    raw_bits.vsync  = !((32'(v_cnt) >= V_SYNC_START) && (32'(v_cnt) < V_SYNC_END));
  end

  assign x_out = raw_bits.active ? COORD_W'(h_cnt) : '0;
  assign y_out = raw_bits.active ? COORD_W'(v_cnt) : '0;

  // Gated by rst so the pulse stays low while the counters are held at 0.
  assign frame_start = rst && (h_cnt == '0) && (v_cnt == '0);

  sync_delay #(
    .DEPTH (PIPE_LAT)
  ) u_sync_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (raw_bits),
    .dout (dly_bits)
  );

  // Output stage: colour is captured together with its delayed timing bits,
  // so syncs and blank leave on the same edge as the pixel they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
    end else begin
      vga_r       <= dly_bits.active ? red   : '0;
      vga_g       <= dly_bits.active ? green : '0;
      vga_b       <= dly_bits.active ? blue  : '0;
      vga_hs      <= dly_bits.hsync;
      vga_vs      <= dly_bits.vsync;
      vga_blank_n <= dly_bits.active;
    end
  end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout
//   Three scan-outs run side by side: the default 640x480 timing with
//   PIPE_LAT 4, and a shrunken raster (55x19 clocks per frame) with PIPE_LAT
//   1 and 15 so that whole frames fit in a short run. A raster model derived
//   from clock count since reset release predicts every output each cycle.
module tb_vga_scanout;

  localparam int NCFG = 3;
  localparam int HA_C [NCFG] = '{640, 40, 40};
  localparam int HF_C [NCFG] = '{16, 4, 4};
  localparam int HS_C [NCFG] = '{96, 6, 6};
  localparam int HB_C [NCFG] = '{48, 5, 5};
  localparam int VA_C [NCFG] = '{480, 12, 12};
  localparam int VF_C [NCFG] = '{10, 2, 2};
  localparam int VS_C [NCFG] = '{2, 2, 2};
  localparam int VB_C [NCFG] = '{33, 3, 3};
  localparam int LAT_C [NCFG] = '{4, 1, 15};
  localparam int EXP_RISE [NCFG] = '{5, 2, 16};

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NCFG-1:0][9:0] x_o, y_o, red_i, green_i, blue_i, vr, vg, vb;
  logic [NCFG-1:0]      hs, vs, bn, fs;

  int n = 0;
  int checks = 0;
  int fails = 0;

  logic [9:0] hist_g [NCFG][64];
  logic [9:0] hist_b [NCFG][64];
  logic prev_bn [NCFG];
  bit   rise_seen [NCFG];
  logic prev_hs0 = 1'b1;
  logic prev_vs1 = 1'b1;
  int   hs_run = 0;
  int   hs_runs = 0;
  int   last_vs_fall = -1;
  int   last_fs = -1;
  int   vs_periods = 0;
  int   fs_periods = 0;

  always #5 clk = ~clk;

  vga_scanout dut0 (
    .clk(clk), .rst(rst), .x_out(x_o[0]), .y_out(y_o[0]),
    .red(red_i[0]), .green(green_i[0]), .blue(blue_i[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(vb[0]),
    .vga_hs(hs[0]), .vga_vs(vs[0]), .vga_blank_n(bn[0]), .frame_start(fs[0])
  );

  for (genvar g = 1; g < NCFG; g++) begin : g_small
    vga_scanout #(
      .H_ACTIVE(HA_C[g]), .H_FRONT(HF_C[g]), .H_SYNC(HS_C[g]), .H_BACK(HB_C[g]),
      .V_ACTIVE(VA_C[g]), .V_FRONT(VF_C[g]), .V_SYNC(VS_C[g]), .V_BACK(VB_C[g]),
      .PIPE_LAT(LAT_C[g])
    ) dut (
      .clk(clk), .rst(rst), .x_out(x_o[g]), .y_out(y_o[g]),
      .red(red_i[g]), .green(green_i[g]), .blue(blue_i[g]),
      .vga_r(vr[g]), .vga_g(vg[g]), .vga_b(vb[g]),
      .vga_hs(hs[g]), .vga_vs(vs[g]), .vga_blank_n(bn[g]), .frame_start(fs[g])
    );
  end

  // Clocks elapsed since reset release; zero while reset is held.
  always @(posedge clk or negedge rst) begin
    if (!rst) n = 0;
    else      n = n + 1;
  end

  // Raster model: position k clocks after release, from plain arithmetic.
  function automatic int htot(input int g);
    return HA_C[g] + HF_C[g] + HS_C[g] + HB_C[g];
  endfunction

  function automatic int vtot(input int g);
    return VA_C[g] + VF_C[g] + VS_C[g] + VB_C[g];
  endfunction

  function automatic int col(input int g, input int k);
    return k % htot(g);
  endfunction

  function automatic int row(input int g, input int k);
    return (k / htot(g)) % vtot(g);
  endfunction

  function automatic bit in_active(input int g, input int k);
    return (col(g, k) < HA_C[g]) && (row(g, k) < VA_C[g]);
  endfunction

  function automatic bit hs_level(input int g, input int k);
    int c;
    c = col(g, k);
    return !((c >= HA_C[g] + HF_C[g]) && (c < HA_C[g] + HF_C[g] + HS_C[g]));
  endfunction

  function automatic bit vs_level(input int g, input int k);
    int r;
    r = row(g, k);
    return !((r >= VA_C[g] + VF_C[g]) && (r < VA_C[g] + VF_C[g] + VS_C[g]));
  endfunction

  task automatic checkOutput(input string name, input int g,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s cfg%0d n=%0d t=%0t: got %0d, expected %0d",
               name, g, n, $time, actual, expected);
    end
  endtask

  task automatic checkIdle(input int g);
    checkOutput("vga_r_idle", g, vr[g], 0);
    checkOutput("vga_g_idle", g, vg[g], 0);
    checkOutput("vga_b_idle", g, vb[g], 0);
    checkOutput("vga_hs_idle", g, hs[g], 1);
    checkOutput("vga_vs_idle", g, vs[g], 1);
    checkOutput("blank_n_idle", g, bn[g], 0);
  endtask

  task automatic compareCycle(input int g);
    int  m;
    bit  a_now;
    bit  a_d;
    if (!rst) begin
      checkOutput("x_out_rst", g, x_o[g], 0);
      checkOutput("y_out_rst", g, y_o[g], 0);
      checkOutput("frame_start_rst", g, fs[g], 0);
      checkIdle(g);
    end else begin
      a_now = in_active(g, n);
      checkOutput("x_out", g, x_o[g], a_now ? col(g, n) : 0);
      checkOutput("y_out", g, y_o[g], a_now ? row(g, n) : 0);
      checkOutput("frame_start", g, fs[g], (col(g, n) == 0 && row(g, n) == 0) ? 1 : 0);
      m = n - LAT_C[g] - 1;
      if (m < 0) begin
        checkIdle(g);
      end else begin
        a_d = in_active(g, m);
        checkOutput("blank_n", g, bn[g], a_d);
        checkOutput("vga_hs", g, hs[g], hs_level(g, m));
        checkOutput("vga_vs", g, vs[g], vs_level(g, m));
        checkOutput("vga_r", g, vr[g], a_d ? col(g, m) : 0);
        checkOutput("vga_g", g, vg[g], a_d ? hist_g[g][(n-1) % 64] : 10'd0);
        checkOutput("vga_b", g, vb[g], a_d ? hist_b[g][(n-1) % 64] : 10'd0);
      end
    end
  endtask

  // Edge-level measurements pinned to hand-computed literals.
  task automatic trackEvents();
    if (!rst) begin
      for (int g = 0; g < NCFG; g++) begin
        prev_bn[g] = 1'b0;
        rise_seen[g] = 1'b0;
      end
      prev_hs0 = 1'b1;
      prev_vs1 = 1'b1;
      hs_run = 0;
      last_vs_fall = -1;
      last_fs = -1;
      return;
    end
    for (int g = 0; g < NCFG; g++) begin
      if (bn[g] && !prev_bn[g] && !rise_seen[g]) begin
        checkOutput("blank_first_rise", g, n, EXP_RISE[g]);
        rise_seen[g] = 1'b1;
      end
      prev_bn[g] = bn[g];
    end
    if (!hs[0]) begin
      if (prev_hs0) checkOutput("hs_fall_column", 0, (n - 5) % 800, 656);
      hs_run++;
    end else begin
      if (!prev_hs0) begin
        checkOutput("hs_low_width", 0, hs_run, 96);
        hs_runs++;
      end
      hs_run = 0;
    end
    prev_hs0 = hs[0];
    if (!vs[1] && prev_vs1) begin
      if (last_vs_fall >= 0) begin
        checkOutput("vs_period", 1, n - last_vs_fall, 1045);
        vs_periods++;
      end
      last_vs_fall = n;
    end
    prev_vs1 = vs[1];
    if (fs[1]) begin
      checkOutput("fs_at_origin", 1, {x_o[1], y_o[1]}, 0);
      if (last_fs >= 0) begin
        checkOutput("fs_period", 1, n - last_fs, 1045);
        fs_periods++;
      end
      last_fs = n;
    end
  endtask

  // Colour generator: red echoes the column requested PIPE_LAT clocks ago
  // (random/full-scale while that request was blanked); green and blue are
  // random with frequent full-scale values to expose missing blanking.
  task automatic applyStimulus();
    for (int g = 0; g < NCFG; g++) begin
      int k;
      logic [9:0] gv;
      logic [9:0] bv;
      k = n - LAT_C[g];
      if (k >= 0 && in_active(g, k)) red_i[g] = 10'(col(g, k));
      else red_i[g] = ($urandom_range(0, 1) == 0) ? 10'h3FF : 10'($urandom);
      gv = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      bv = ($urandom_range(0, 3) == 0) ? 10'h3FF : 10'($urandom);
      green_i[g] = gv;
      blue_i[g]  = bv;
      hist_g[g][n % 64] = gv;
      hist_b[g][n % 64] = bv;
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NCFG; g++) compareCycle(g);
    trackEvents();
    applyStimulus();
  end

  initial begin
    int guard;
    red_i = '0;
    green_i = '0;
    blue_i = '0;
    $display("[TB] vga_scanout bench starting");

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checkOutput("fs_on_release", g, fs[g], 1);
      checkOutput("x_on_release", g, x_o[g], 0);
    end

    // Run to column 300, row 10 of the default raster, then pull reset
    // between edges and confirm the outputs drop without a clock.
    guard = 0;
    while (n < 8300 && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("reach_reset_point", 0, n, 8300);
    #1 rst = 1'b0;
    #1;
    checkOutput("async_blank_n", 0, bn[0], 0);
    checkOutput("async_vga_r", 0, vr[0], 0);
    checkOutput("async_vga_hs", 0, hs[0], 1);
    checkOutput("async_x_out", 0, x_o[0], 0);
    checkOutput("async_frame_start", 0, fs[0], 0);

    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checkOutput("fs_on_rerelease", g, fs[g], 1);
    end

    repeat (20000) @(negedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) begin
      checkOutput("blank_rise_seen", g, rise_seen[g], 1);
    end
    checkOutput("hs_runs_seen", 0, (hs_runs >= 30) ? 1 : 0, 1);
    checkOutput("vs_periods_seen", 1, (vs_periods >= 20) ? 1 : 0, 1);
    checkOutput("fs_periods_seen", 1, (fs_periods >= 20) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
